// File: rtl/alu.sv
// Registered 32-bit integer ALU for the execute stage, using MIPS-style ALU-control codes.
// Result and zero flag are computed combinationally, then registered together.
module alu (
  input  logic [31:0] din_A,
  input  logic [31:0] din_B,
  input  logic [3:0]  op,
  output logic        zero,
  output logic [31:0] dout,
  input  logic        clk,
  input  logic        rst_n
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_SRL  = 4'b0100,
    OP_SRA  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_NOR  = 4'b1100,
    OP_XOR  = 4'b1101
  } op_e;

  logic [31:0] result;
  logic [4:0]  shamt;

  assign shamt = din_B[4:0];

  // Unlisted codes fall through to the default zero result.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = din_A & din_B;
      OP_OR:   result = din_A | din_B;
      OP_ADD:  result = din_A + din_B;
      OP_SLL:  result = din_A << shamt;
      OP_SRL:  result = din_A >> shamt;
      OP_SRA:  result = $signed(din_A) >>> shamt;
      OP_SUB:  result = din_A - din_B;
      OP_SLT:  result = {31'd0, $signed(din_A) < $signed(din_B)};
      OP_SLTU: result = {31'd0, din_A < din_B};
      OP_NOR:  result = ~(din_A | din_B);
      OP_XOR:  result = din_A ^ din_B;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      zero <= 1'b1;
    end else begin
      dout <= result;
      zero <= (result == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for the registered ALU plus hand-written reset and timing sequences.
module tb_alu;

  logic [31:0] din_A, din_B;
  logic [3:0]  op;
  logic        zero;
  logic [31:0] dout;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  alu dut (
    .din_A (din_A),
    .din_B (din_B),
    .op    (op),
    .zero  (zero),
    .dout  (dout),
    .clk   (clk),
    .rst_n (rst_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got_d, input logic got_z,
                       input logic [31:0] exp_d, input logic exp_z);
    n_cmp++;
    if (got_d !== exp_d || got_z !== exp_z) begin
      n_bad++;
      $display("FAIL %s: dout=%h zero=%b, expected dout=%h zero=%b",
               name, got_d, got_z, exp_d, exp_z);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
    @(negedge clk);
    din_A = a;
    din_B = b;
    op    = o;
  endtask

  initial begin
    vecs.push_back('{32'h0000BEEF, 32'h0000CAFE, 4'b0000, 32'h00008AEE, "and"});
    vecs.push_back('{32'h0000BEEF, 32'h0000CAFE, 4'b0001, 32'h0000FEFF, "or"});
    vecs.push_back('{32'h0000BEEF, 32'h0000CAFE, 4'b1100, 32'hFFFF0100, "nor"});
    vecs.push_back('{32'h0000BEEF, 32'h0000CAFE, 4'b1101, 32'h00007411, "xor"});
    vecs.push_back('{32'h0000BEEF, 32'h0000CAFE, 4'b0010, 32'h000189ED, "add"});
    vecs.push_back('{32'h0000BEEF, 32'h0000CAFE, 4'b0110, 32'hFFFFF3F1, "sub"});
    vecs.push_back('{32'h12345678, 32'h12345678, 4'b0110, 32'h00000000, "sub_eq"});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, "add_wrap"});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, "slt_neg"});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 4'b1000, 32'h00000000, "sltu_big"});
    vecs.push_back('{32'h0000BEEF, 32'h0000CAFE, 4'b0111, 32'h00000001, "slt_pos"});
    vecs.push_back('{32'h80000000, 32'h00000001, 4'b0111, 32'h00000001, "slt_min"});
    vecs.push_back('{32'h80000000, 32'h00000001, 4'b1000, 32'h00000000, "sltu_min"});
    vecs.push_back('{32'h00000001, 32'hFFFFFFFF, 4'b0111, 32'h00000000, "slt_gt"});
    vecs.push_back('{32'h00000001, 32'hFFFFFFFF, 4'b1000, 32'h00000001, "sltu_lt"});
    vecs.push_back('{32'h80000010, 32'h00000004, 4'b0011, 32'h00000100, "sll4"});
    vecs.push_back('{32'h80000010, 32'h00000004, 4'b0100, 32'h08000001, "srl4"});
    vecs.push_back('{32'h80000010, 32'h00000004, 4'b0101, 32'hF8000001, "sra4"});
    vecs.push_back('{32'h80000010, 32'h00000020, 4'b0011, 32'h80000010, "sll0"});
    vecs.push_back('{32'h80000010, 32'h00000000, 4'b0101, 32'h80000010, "sra0"});
    vecs.push_back('{32'h80000000, 32'h0000001F, 4'b0100, 32'h00000001, "srl31"});
    vecs.push_back('{32'h80000000, 32'h0000001F, 4'b0101, 32'hFFFFFFFF, "sra31"});
    vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 4'b1111, 32'h00000000, "op1111"});
    vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 4'b1001, 32'h00000000, "op1001"});
    vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 4'b1010, 32'h00000000, "op1010"});
    vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 4'b1011, 32'h00000000, "op1011"});
    vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 4'b1110, 32'h00000000, "op1110"});

    // Reset with arbitrary inputs and no clock edge yet.
    din_A = 32'hDEADBEEF;
    din_B = 32'h01234567;
    op    = 4'b0001;
    #1 rst_n = 1'b0;
    #2 check("reset_async", dout, zero, 32'h0, 1'b1);

    apply(32'h0, 32'h0, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_edge", dout, zero, 32'h0, 1'b1);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].op);
      @(posedge clk); #1;
      check(vecs[i].name, dout, zero, vecs[i].exp, vecs[i].exp == 32'h0);
    end

    // Inputs changed between edges must not reach the outputs until the next edge.
    apply(32'h0000BEEF, 32'h0000CAFE, 4'b0001);
    @(posedge clk); #2;
    din_A = 32'h0000000F;
    din_B = 32'h000000F0;
    op    = 4'b0000;
    #2 check("hold_between_edges", dout, zero, 32'h0000FEFF, 1'b0);
    @(posedge clk); #1;
    check("update_next_edge", dout, zero, 32'h00000000, 1'b1);

    // Mid-stream reset clears immediately and discards the pending result.
    apply(32'h00000003, 32'h00000004, 4'b0010);
    @(posedge clk); #1;
    check("pre_reset", dout, zero, 32'h00000007, 1'b0);
    #1 rst_n = 1'b0;
    #1 check("reset_midstream", dout, zero, 32'h0, 1'b1);
    @(posedge clk); #1;
    check("reset_held", dout, zero, 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release", dout, zero, 32'h00000007, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
